// File: rtl/memory_pkg.sv
// Shared definitions for the memory block and its two-port arbiter.
package memory_pkg;

  localparam int MEM_ADDR_WIDTH = 12;
  localparam int MEM_DATA_WIDTH = 31;

  typedef enum logic [1:0] {
    ARB_IDLE    = 2'd0,
    ARB_BUSY    = 2'd1,
    ARB_RELEASE = 2'd2
  } arb_state_e;

endpackage

// File: rtl/rr_pick2.sv
// Two-way round-robin selector: on contention the port that was not last granted wins.
module rr_pick2 (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic gnt_vld,
  output logic gnt_port
);

  assign gnt_vld  = req0 | req1;
  assign gnt_port = (req0 & req1) ? ~last_owner : req1;

endmodule

// File: rtl/memory_arbiter.sv
// Shares one enable/finish memory between two requesters with round-robin
// grant, a one-cycle release gap after every transfer and a hang watchdog.
module memory_arbiter
  import memory_pkg::*;
#(
  parameter int ADDR_WIDTH     = MEM_ADDR_WIDTH,
  parameter int DATA_WIDTH     = MEM_DATA_WIDTH,
  parameter int TIMEOUT_CYCLES = 4095
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  r0_write_enable,
  input  logic                  r0_read_enable,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_write_data,
  output logic                  r0_done,
  output logic                  r0_error,
  output logic [DATA_WIDTH-1:0] r0_read_data,
  input  logic                  r1_write_enable,
  input  logic                  r1_read_enable,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_write_data,
  output logic                  r1_done,
  output logic                  r1_error,
  output logic [DATA_WIDTH-1:0] r1_read_data,
  output logic                  mem_write_enable,
  output logic                  mem_read_enable,
  input  logic                  mem_finish,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  input  logic [DATA_WIDTH-1:0] mem_read_data,
  output logic                  busy,
  output logic                  owner
);

  localparam logic [ADDR_WIDTH-1:0] WDOG_LAST = ADDR_WIDTH'(TIMEOUT_CYCLES - 1);

  logic [1:0]                 req_we, req_re;
  logic [1:0][ADDR_WIDTH-1:0] req_addr;
  logic [1:0][DATA_WIDTH-1:0] req_wd;

  assign req_we   = {r1_write_enable, r0_write_enable};
  assign req_re   = {r1_read_enable, r0_read_enable};
  assign req_addr = {r1_addr, r0_addr};
  assign req_wd   = {r1_write_data, r0_write_data};

  arb_state_e                 state_q, state_d;
  logic                       owner_q, owner_d;
  logic                       mem_we_q, mem_we_d, mem_re_q, mem_re_d;
  logic [ADDR_WIDTH-1:0]      addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [1:0]                 done_q, done_d, err_q, err_d;
  logic [1:0][DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic [ADDR_WIDTH-1:0]      wdog_q, wdog_d;

  logic gnt_vld, gnt_port, wdog_exp;

  rr_pick2 u_pick (
    .req0       (req_we[0] | req_re[0]),
    .req1       (req_we[1] | req_re[1]),
    .last_owner (owner_q),
    .gnt_vld    (gnt_vld),
    .gnt_port   (gnt_port)
  );

  assign wdog_exp = (TIMEOUT_CYCLES != 0) && (wdog_q == WDOG_LAST);

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ARB_IDLE:    if (gnt_vld) state_d = ARB_BUSY;
      ARB_BUSY:    if (mem_finish || wdog_exp) state_d = ARB_RELEASE;
      ARB_RELEASE: state_d = ARB_IDLE;
      default:     state_d = ARB_IDLE;
    endcase
  end

  // Datapath next-state: latch on grant, hold through BUSY, complete on finish or expiry.
  always_comb begin
    owner_d  = owner_q;
    mem_we_d = mem_we_q;
    mem_re_d = mem_re_q;
    addr_d   = addr_q;
    wdata_d  = wdata_q;
    done_d   = '0;
    err_d    = '0;
    rdata_d  = rdata_q;
    wdog_d   = wdog_q;
    unique case (state_q)
      ARB_IDLE: begin
        if (gnt_vld) begin
          owner_d  = gnt_port;
          addr_d   = req_addr[gnt_port];
          wdata_d  = req_wd[gnt_port];
          // a write wins when both enables are raised together
          mem_we_d = req_we[gnt_port];
          mem_re_d = ~req_we[gnt_port];
          wdog_d   = '0;
        end
      end
      ARB_BUSY: begin
        if (mem_finish) begin
          mem_we_d        = 1'b0;
          mem_re_d        = 1'b0;
          done_d[owner_q] = 1'b1;
          if (mem_re_q) rdata_d[owner_q] = mem_read_data;
        end else if (wdog_exp) begin
          mem_we_d         = 1'b0;
          mem_re_d         = 1'b0;
          done_d[owner_q]  = 1'b1;
          err_d[owner_q]   = 1'b1;
          rdata_d[owner_q] = '0;
        end else if (wdog_q != '1) begin
          wdog_d = wdog_q + ADDR_WIDTH'(1);
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= ARB_IDLE;
      owner_q  <= 1'b1;
      mem_we_q <= 1'b0;
      mem_re_q <= 1'b0;
      addr_q   <= '0;
      wdata_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
      rdata_q  <= '0;
      wdog_q   <= '0;
    end else begin
      state_q  <= state_d;
      owner_q  <= owner_d;
      mem_we_q <= mem_we_d;
      mem_re_q <= mem_re_d;
      addr_q   <= addr_d;
      wdata_q  <= wdata_d;
      done_q   <= done_d;
      err_q    <= err_d;
      rdata_q  <= rdata_d;
      wdog_q   <= wdog_d;
    end
  end

  always_comb begin
    busy             = (state_q != ARB_IDLE);
    owner            = owner_q;
    mem_write_enable = mem_we_q;
    mem_read_enable  = mem_re_q;
    mem_addr         = addr_q;
    mem_write_data   = wdata_q;
    r0_done          = done_q[0];
    r1_done          = done_q[1];
    r0_error         = err_q[0];
    r1_error         = err_q[1];
    r0_read_data     = rdata_q[0];
    r1_read_data     = rdata_q[1];
  end

endmodule

// File: tb/tb_memory_arbiter.sv
// Randomized and directed check of memory_arbiter against a transaction-level model.
module tb_memory_arbiter;
  localparam int AW = 12;
  localparam int DW = 31;

  logic clk = 1'b0, resetn = 1'b0;
  logic [1:0] r_we = '0, r_re = '0;
  logic [AW-1:0] r_addr [2];
  logic [DW-1:0] r_wd [2];
  logic done0, done1, err0, err1;
  logic [DW-1:0] rd0, rd1;
  logic mem_we, mem_re, busy, owner;
  logic mem_finish = 1'b0;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wd, mem_rd = '0;

  always #5 clk = ~clk;

  memory_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(8)) dut (
    .clk(clk), .resetn(resetn),
    .r0_write_enable(r_we[0]), .r0_read_enable(r_re[0]), .r0_addr(r_addr[0]),
    .r0_write_data(r_wd[0]), .r0_done(done0), .r0_error(err0), .r0_read_data(rd0),
    .r1_write_enable(r_we[1]), .r1_read_enable(r_re[1]), .r1_addr(r_addr[1]),
    .r1_write_data(r_wd[1]), .r1_done(done1), .r1_error(err1), .r1_read_data(rd1),
    .mem_write_enable(mem_we), .mem_read_enable(mem_re), .mem_finish(mem_finish),
    .mem_addr(mem_addr), .mem_write_data(mem_wd), .mem_read_data(mem_rd),
    .busy(busy), .owner(owner)
  );

  // Stub memory with programmable latency; stall holds off finish forever.
  logic [DW-1:0] smem [4096] = '{default: '0};
  int lat_cnt = 0, mem_lat = 1;
  bit stall = 1'b0;
  always @(posedge clk) begin
    mem_finish <= 1'b0;
    if (!(mem_we || mem_re)) lat_cnt <= 0;
    else if (!stall && !mem_finish) begin
      if (lat_cnt >= mem_lat) begin
        mem_finish <= 1'b1;
        lat_cnt    <= 0;
        if (mem_we) smem[mem_addr] <= mem_wd;
        else        mem_rd <= smem[mem_addr];
      end else lat_cnt <= lat_cnt + 1;
    end
  end

  // Grant monitor: snapshot of each memory-enable window.
  int cyc = 0, g_cyc = 0, en_run = 0;
  int dcnt [2] = '{0, 0};
  logic g_we = 1'b0, g_re = 1'b0, g_own = 1'b0, en_prev = 1'b0;
  logic [AW-1:0] g_addr = '0;
  logic [DW-1:0] g_wd = '0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) begin
    en_prev <= mem_we | mem_re;
    if (mem_we | mem_re) begin
      if (!en_prev) begin
        g_we <= mem_we; g_re <= mem_re; g_own <= owner;
        g_addr <= mem_addr; g_wd <= mem_wd; g_cyc <= cyc; en_run <= 1;
      end else en_run <= en_run + 1;
    end
    if (done0) dcnt[0] <= dcnt[0] + 1;
    if (done1) dcnt[1] <= dcnt[1] + 1;
  end

  // Reference model: flat word store plus round-robin owner.
  logic [DW-1:0] ref_mem [int];
  int m_owner = 1;
  int exp_dcnt [2] = '{0, 0};
  int total = 0, bad = 0, last_done = 0;

  function automatic logic [DW-1:0] ref_rd(input logic [AW-1:0] a);
    return ref_mem.exists(int'(a)) ? ref_mem[int'(a)] : '0;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk); #1;
  endtask

  task automatic wait_done(input int p, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if ((p == 0) ? done0 : done1) begin ok = 1'b1; break; end
    end
    if (!ok) chk("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_grant(output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      tick();
      if (mem_we | mem_re) begin ok = 1'b1; break; end
    end
    if (!ok) chk("grant_timeout", 32'd0, 32'd1);
  endtask

  // op = {write, read}; both ports raise in the same cycle when both active.
  task automatic xfer(input bit a0, input bit a1, input bit [1:0] op0, input bit [1:0] op1,
                      input logic [AW-1:0] ad0, input logic [AW-1:0] ad1,
                      input logic [DW-1:0] d0, input logic [DW-1:0] d1);
    int order [$];
    bit [1:0] op [2];
    bit ok;
    op[0] = op0; op[1] = op1;
    r_addr[0] = ad0; r_addr[1] = ad1; r_wd[0] = d0; r_wd[1] = d1;
    r_we = {a1 & op1[1], a0 & op0[1]};
    r_re = {a1 & op1[0], a0 & op0[0]};
    if (a0 && a1) begin order.push_back(1 - m_owner); order.push_back(m_owner); end
    else order.push_back(a1 ? 1 : 0);
    foreach (order[k]) begin
      int p = order[k];
      wait_done(p, ok);
      if (ok) begin
        exp_dcnt[p]++;
        last_done = cyc;
        chk("done_cnt0", dcnt[0], exp_dcnt[0]);
        chk("done_cnt1", dcnt[1], exp_dcnt[1]);
        chk("error", (p == 0) ? err0 : err1, 0);
        chk("gnt_port", g_own, p);
        chk("gnt_we", g_we, op[p][1]);
        chk("gnt_re", g_re, !op[p][1]);
        chk("gnt_addr", g_addr, r_addr[p]);
        if (op[p][1]) begin
          chk("gnt_wdata", g_wd, r_wd[p]);
          ref_mem[int'(r_addr[p])] = r_wd[p];
        end else chk("rdata", (p == 0) ? rd0 : rd1, ref_rd(r_addr[p]));
        chk("release_en", {mem_we, mem_re}, 0);
        chk("release_busy", busy, 1);
      end
      r_we[p] = 1'b0; r_re[p] = 1'b0; m_owner = p;
      tick();
      chk("done_pulse", (p == 0) ? done0 : done1, 0);
      chk("idle_gap", {busy, mem_we, mem_re}, 0);
    end
  endtask

  initial begin
    bit ok;
    int prev_done;
    logic [AW-1:0] apool [4];
    apool[0] = 12'o0017; apool[1] = 12'o0100; apool[2] = 12'o0001; apool[3] = 12'o7777;
    r_addr[0] = '0; r_addr[1] = '0; r_wd[0] = '0; r_wd[1] = '0;

    repeat (3) tick();
    chk("rst_en", {mem_we, mem_re}, 0);
    chk("rst_addr", mem_addr, 0);
    chk("rst_wdata", mem_wd, 0);
    chk("rst_done_err", {done0, done1, err0, err1}, 0);
    chk("rst_rdata", rd0 | rd1, 0);
    chk("rst_busy", busy, 0);
    chk("rst_owner", owner, 1);
    resetn = 1'b1;

    // simultaneous reads: port 0 first after reset, then the owner flips
    xfer(1, 1, 2'b01, 2'b01, 12'o0001, 12'o7777, '0, '0);
    xfer(1, 1, 2'b01, 2'b01, 12'o0001, 12'o7777, '0, '0);

    // port 0 write then read back
    xfer(1, 0, 2'b10, 2'b00, 12'o0017, '0, 31'o1234567012, '0);
    xfer(1, 0, 2'b01, 2'b00, 12'o0017, '0, '0, '0);
    chk("p0_readback", rd0, 31'o1234567012);

    // both enables on port 1 is a write
    xfer(0, 1, 2'b00, 2'b11, '0, 12'o0100, '0, 31'o0000000001);
    xfer(0, 1, 2'b00, 2'b01, '0, 12'o0100, '0, '0);
    chk("both_en_readback", rd1, 31'o0000000001);

    // back-to-back on port 0: request re-raised right after the release cycle
    xfer(1, 0, 2'b10, 2'b00, 12'o0001, '0, 31'h1234567, '0);
    prev_done = last_done;
    xfer(1, 0, 2'b01, 2'b00, 12'o0001, '0, '0, '0);
    chk("b2b_gap", g_cyc - prev_done, 2);

    for (int i = 0; i < 24; i++) begin
      int pat;
      pat = $urandom_range(0, 2);
      mem_lat = $urandom_range(0, 4);
      xfer(pat != 1, pat != 0, 2'($urandom_range(1, 3)), 2'($urandom_range(1, 3)),
           apool[$urandom_range(0, 3)], apool[$urandom_range(0, 3)],
           31'($urandom), 31'($urandom));
      repeat ($urandom_range(0, 2)) tick();
    end

    // watchdog: memory never finishes, port 1 waits behind the hung transfer
    stall = 1'b1;
    r_addr[0] = 12'o0200; r_re[0] = 1'b1;
    wait_grant(ok);
    r_addr[1] = 12'o0017; r_re[1] = 1'b1;
    wait_done(0, ok);
    exp_dcnt[0]++;
    chk("wd_cycles", en_run, 8);
    chk("wd_error", err0, 1);
    chk("wd_rdata", rd0, 0);
    chk("wd_en_low", {mem_we, mem_re}, 0);
    chk("wd_dcnt0", dcnt[0], exp_dcnt[0]);
    r_re[0] = 1'b0; stall = 1'b0;
    wait_done(1, ok);
    exp_dcnt[1]++;
    chk("wd_next_port", g_own, 1);
    chk("wd_next_err", err1, 0);
    chk("wd_next_rdata", rd1, ref_rd(12'o0017));
    chk("wd_dcnt1", dcnt[1], exp_dcnt[1]);
    r_re[1] = 1'b0; m_owner = 1;
    tick();

    // reset in the middle of a port 1 transfer
    stall = 1'b1;
    r_addr[1] = 12'o0100; r_re[1] = 1'b1;
    wait_grant(ok);
    repeat (3) tick();
    resetn = 1'b0; #1;
    chk("mid_rst_en", {mem_we, mem_re}, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_done", {done0, done1}, 0);
    chk("mid_rst_owner", owner, 1);
    stall = 1'b0;
    tick(); tick();
    resetn = 1'b1; m_owner = 1;
    wait_done(1, ok);
    exp_dcnt[1]++;
    chk("post_rst_port", g_own, 1);
    chk("post_rst_err", err1, 0);
    chk("post_rst_rdata", rd1, ref_rd(12'o0100));
    chk("post_rst_dcnt0", dcnt[0], exp_dcnt[0]);
    chk("post_rst_dcnt1", dcnt[1], exp_dcnt[1]);
    r_re[1] = 1'b0;
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
